// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC walker and instruction fetcher for the 16-bit RISC core.
// Issues one outstanding req/ack fetch at a time and buffers returned words in
// a 2-entry queue whose head is presented to decode. Branch redirects flush
// the queue and retarget the PC; a response already in flight is discarded.
// Optional feature: define IFU_HALT_DETECT_EN to stop fetching after a HALT
// (opcode 3'b011) word until the next redirect.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [15:0]       id_instr,
    output logic [2:0]        id_opcode,
    output logic [ADDR_W-1:0] id_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        count_q, count_d;
    logic [15:0]       instr0_q, instr0_d, instr1_q, instr1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

    logic              ack;
    logic              push;
    logic              pop;
    logic              issue;
    logic              halt_hit;

    // Outputs come straight from registered state and queue slot 0 (the head).
    assign imem_req  = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr = addr_q;
    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = instr0_q;
    assign id_opcode = instr0_q[15:13];
    assign id_pc     = pc0_q;
`ifdef IFU_HALT_DETECT_EN
    assign halted    = (state_q == HALTED);
`else
    assign halted    = 1'b0;
`endif

    // Next-state logic: fetch FSM, PC update and queue push/pop bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        count_d  = count_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        issue    = 1'b0;
        halt_hit = 1'b0;

        ack  = imem_req && imem_ack;
        push = (state_q == WAIT) && ack && !redirect;
        pop  = id_valid && id_ready && !redirect;
`ifdef IFU_HALT_DETECT_EN
        halt_hit = push && (imem_rdata[15:13] == 3'b011);
`endif

        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end

        // Shift the queue on pop; a push lands in the first free slot after it.
        if (pop) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
        end
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                instr0_d = imem_rdata;
                pc0_d    = addr_q;
            end else begin
                instr1_d = imem_rdata;
                pc1_d    = addr_q;
            end
        end

        unique case (state_q)
            IDLE:   issue = 1'b1;
            WAIT: begin
                if (ack) begin
                    issue = 1'b1;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP:   issue = ack;
            HALTED: issue = redirect;
        endcase

        // Only request when the queue is guaranteed room for the response.
        if (issue) begin
            if (halt_hit) begin
                state_d = HALTED;
            end else if (count_d <= 2'd1) begin
                state_d = WAIT;
                addr_d  = pc_d;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State, PC and queue registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end

endmodule
